load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Multi-cycle load unit between the pipeline's M stage and word-organised data memory.
- Accepts a load request (address + op) over a valid/ready handshake.
- Issues one or two word-aligned memory reads. A second read is issued only for misaligned accesses that straddle a word boundary.
- Extracts, assembles and sign/zero-extends the result, then returns it over a valid/ready response handshake.
- Parametrised successor of the combinational load data extractor: adds LHU/LBU, configurable width and misalignment policy.

Parameters:
- DATA_W, 32, word width in bits; a power of two, ≥16, multiple of 8. NB = DATA_W/8 bytes per word.
- ADDR_W, 32, byte-address width.
- SUPPORT_UNALIGNED, 1, 1 = split boundary-crossing accesses into two reads; 0 = flag misalignment as an error.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  ADDR_W  byte address
- req_op  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU; 5..7 treated as LW
- mem_req_valid  out  1  memory read request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  word-aligned read address (low log2(NB) bits zero)
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read word, little-endian byte lanes
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  DATA_W  extended load result
- resp_err  out  1  misaligned access rejected (only when SUPPORT_UNALIGNED=0)

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; req_ready=1; mem_req_valid=0; mem_addr=0; resp_valid=0; resp_data=0; resp_err=0. Reset aborts any in-flight operation. A mem_rvalid arriving after reset is ignored.
- Access size: LW = NB bytes; LH/LHU = 2 bytes; LB/LBU = 1 byte. off = req_addr mod NB.
- cross = (off + size > NB). mis = (req_addr mod size ≠ 0).
- Request, address, op and off are latched on acceptance (req_valid & req_ready).
- FSM:
  - IDLE: req_ready=1. On accept:
    - SUPPORT_UNALIGNED=0 and mis → RESP with resp_err=1, resp_data=0, no memory access.
    - Otherwise → REQ0.
  - REQ0: mem_req_valid=1, mem_addr = addr with low bits cleared. On mem_req_ready → WAIT0.
  - WAIT0: on mem_rvalid, capture lo word. If cross → REQ1, else → RESP.
  - REQ1: mem_req_valid=1, mem_addr = first word address + NB (wraps modulo 2^ADDR_W). On mem_req_ready → WAIT1.
  - WAIT1: on mem_rvalid, capture hi word → RESP.
  - RESP: resp_valid=1. resp_data and resp_err stay stable until resp_ready. On resp_valid & resp_ready → IDLE.
- req_ready=0 in every state except IDLE. There is no request pipelining; one load is outstanding at a time.
- Memory contract:
  - Exactly one mem_rvalid per accepted memory request, in order.
  - mem_rvalid arrives no earlier than the cycle after the request handshake.
  - mem_rvalid in any other state is ignored.
  - mem_req_valid, once asserted, holds with a stable mem_addr until mem_req_ready.
- Assembly: form {hi, lo} (hi = 0 if not cross), shift right by off×8, take the low size bytes. Sign-extend for LH/LB; zero-extend for LHU/LBU. LW is unextended.
- Latency, zero-wait memory (mem_req_ready=1, rvalid one cycle after handshake):
  - Accept at cycle T → resp_valid at T+3 for a single read, T+5 for a split read.
  - Rejected misaligned access → resp_valid at T+1.
- Back-to-back: request accepted in the cycle after the response handshake, earliest.

Test Plan:
- mem[0x100]=0x807060F0, mem[0x104]=0x11223344, SUPPORT_UNALIGNED=1, zero-wait memory:
  - LB @0x100 → resp_data 0xFFFFFFF0.
  - LBU @0x100 → 0x000000F0.
  - LB @0x101 → 0x00000060.
  - Each: one mem request to 0x100, resp_valid at T+3.
- LH @0x102 → 0xFFFF8070. LHU @0x102 → 0x00008070. LW @0x100 → 0x807060F0; op=7 @0x100 gives the same result.
- LW @0x102 → two mem requests (0x100 then 0x104), resp_data 0x33448070 at T+5. LH @0x103 → 0x00004480 via two reads.
- SUPPORT_UNALIGNED=0, LW @0x102 → resp_err=1, resp_data=0, no mem_req_valid, resp_valid at T+1. LH @0x102 → normal 0xFFFF8070, resp_err=0.
- Backpressure:
  - mem_req_ready low 3 cycles → mem_addr held.
  - mem_rvalid delayed 4 cycles → result unchanged.
  - resp_ready low 5 cycles → resp_valid/resp_data held and req_ready=0 throughout.
- Reset:
  - reset_n=0 during WAIT1 of a split LW → next cycle state IDLE, all outputs at reset values.
  - Late mem_rvalid ignored.
  - New LB @0x101 afterwards returns 0x00000060.

Source files
------------

// File: rtl/load_align_unit.sv
// Multi-cycle load unit: issues one or two word reads, assembles the addressed bytes and
// returns a sign/zero-extended result over a valid/ready response handshake.
module load_align_unit #(
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned ADDR_W            = 32,
  parameter bit          SUPPORT_UNALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_op,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned SZ_W  = OFF_W + 2;

  typedef enum logic [2:0] {StIdle, StReq0, StWait0, StReq1, StWait1, StResp} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                cross_q, cross_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;

  logic [OFF_W-1:0]    req_off;
  logic [SZ_W-1:0]     req_size;
  logic                req_mis;
  logic                req_cross;

  always_comb begin
    req_off = req_addr[OFF_W-1:0];
    case (req_op)
      3'd1, 3'd2: begin
        req_size = SZ_W'(2);
        req_mis  = req_addr[0];
      end
      3'd3, 3'd4: begin
        req_size = SZ_W'(1);
        req_mis  = 1'b0;
      end
      default: begin
        req_size = SZ_W'(NB);
        req_mis  = |req_off;
      end
    endcase
    req_cross = (SZ_W'(req_off) + req_size) > SZ_W'(NB);
  end

  // In WAIT1 the pair is {hi, lo}; in WAIT0 only non-crossing loads finish, so hi is zero.
  logic [2*DATA_W-1:0] pair;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   assembled;

  always_comb begin
    pair    = (state_q == StWait1) ? {mem_rdata, lo_q} : {{DATA_W{1'b0}}, mem_rdata};
    shifted = DATA_W'(pair >> {off_q, 3'b000});
    case (op_q)
      3'd1, 3'd2: begin
        assembled        = {DATA_W{(op_q == 3'd1) & shifted[15]}};
        assembled[15:0]  = shifted[15:0];
      end
      3'd3, 3'd4: begin
        assembled        = {DATA_W{(op_q == 3'd3) & shifted[7]}};
        assembled[7:0]   = shifted[7:0];
      end
      default: assembled = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    cross_d     = cross_q;
    mem_addr_d  = mem_addr_q;
    lo_d        = lo_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = req_op;
          off_d   = req_off;
          cross_d = req_cross;
          if (!SUPPORT_UNALIGNED && req_mis) begin
            state_d     = StResp;
            resp_data_d = '0;
            resp_err_d  = 1'b1;
          end else begin
            state_d    = StReq0;
            mem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
      end
      StReq0: if (mem_req_ready) state_d = StWait0;
      StWait0: begin
        if (mem_rvalid) begin
          lo_d = mem_rdata;
          if (cross_q) begin
            state_d    = StReq1;
            mem_addr_d = mem_addr_q + ADDR_W'(NB);
          end else begin
            state_d     = StResp;
            resp_data_d = assembled;
            resp_err_d  = 1'b0;
          end
        end
      end
      StReq1: if (mem_req_ready) state_d = StWait1;
      StWait1: begin
        if (mem_rvalid) begin
          state_d     = StResp;
          resp_data_d = assembled;
          resp_err_d  = 1'b0;
        end
      end
      StResp: if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      off_q       <= '0;
      cross_q     <= 1'b0;
      mem_addr_q  <= '0;
      lo_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      cross_q     <= cross_d;
      mem_addr_q  <= mem_addr_d;
      lo_q        <= lo_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign mem_req_valid = (state_q == StReq0) || (state_q == StReq1);
  assign resp_valid    = (state_q == StResp);
  assign mem_addr      = mem_addr_q;
  assign resp_data     = resp_data_q;
  assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: two instances (unaligned split / misalignment error)
// share one memory model; expected results go through a scoreboard queue.
module tb_load_align_unit;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic        mem_req_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_ready;

  logic        req_ready_a, mem_req_valid_a, resp_valid_a, resp_err_a;
  logic [31:0] mem_addr_a, resp_data_a;
  logic        req_ready_b, mem_req_valid_b, resp_valid_b, resp_err_b;
  logic [31:0] mem_addr_b, resp_data_b;

  logic        req_valid_a, req_valid_b;
  logic        req_ready, mem_req_valid, resp_valid, resp_err;
  logic [31:0] mem_addr, resp_data;

  assign req_valid_a   = req_valid & ~sel;
  assign req_valid_b   = req_valid & sel;
  assign req_ready     = sel ? req_ready_b     : req_ready_a;
  assign mem_req_valid = sel ? mem_req_valid_b : mem_req_valid_a;
  assign mem_addr      = sel ? mem_addr_b      : mem_addr_a;
  assign resp_valid    = sel ? resp_valid_b    : resp_valid_a;
  assign resp_data     = sel ? resp_data_b     : resp_data_a;
  assign resp_err      = sel ? resp_err_b      : resp_err_a;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .SUPPORT_UNALIGNED(1'b1)) u_dut_a (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid_a),
    .req_ready     (req_ready_a),
    .req_addr      (req_addr),
    .req_op        (req_op),
    .mem_req_valid (mem_req_valid_a),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr_a),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .resp_valid    (resp_valid_a),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data_a),
    .resp_err      (resp_err_a)
  );

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .SUPPORT_UNALIGNED(1'b0)) u_dut_b (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid_b),
    .req_ready     (req_ready_b),
    .req_addr      (req_addr),
    .req_op        (req_op),
    .mem_req_valid (mem_req_valid_b),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr_b),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .resp_valid    (resp_valid_b),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data_b),
    .resp_err      (resp_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [32:0] sb[$];
  logic [31:0] mem_log[$];
  int          rdelay = 0;
  int          rv_cnt = 0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h807060F0;
      32'h104: return 32'h11223344;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Memory acts on the falling edge so its outputs are settled for the next rising edge.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(paddr);
        pend       = 1'b0;
        rv_cnt++;
      end else begin
        cnt--;
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      pend  = 1'b1;
      cnt   = rdelay;
      paddr = mem_addr;
      mem_log.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_load(input string tag, input logic sel_b, input logic [31:0] addr,
                          input logic [2:0] op, input logic [31:0] exp_d, input logic exp_e,
                          input int exp_lat, input int exp_nreq, input int mrdy_lo,
                          input int resp_lo);
    logic [32:0] e;
    logic [31:0] wa;
    int          cyc;
    wa            = {addr[31:2], 2'b00};
    sel           = sel_b;
    mem_req_ready = (mrdy_lo == 0);
    resp_ready    = (resp_lo == 0);
    mem_log.delete();
    chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_op    = op;
    sb.push_back({exp_e, exp_d});
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc       = 1;
    for (int i = 0; i < mrdy_lo; i++) begin
      chk({tag, ".memreq_held_valid"}, 32'(mem_req_valid), 32'd1);
      chk({tag, ".memreq_held_addr"}, mem_addr, wa);
      @(posedge clk); #1;
      cyc++;
    end
    mem_req_ready = 1'b1;
    while (!resp_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    if (exp_lat > 0) chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    for (int i = 0; i < resp_lo; i++) begin
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_data"}, resp_data, exp_d);
      chk({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    e = sb.pop_front();
    chk({tag, ".data"}, resp_data, e[31:0]);
    chk({tag, ".err"}, 32'(resp_err), 32'(e[32]));
    @(posedge clk); #1;
    chk({tag, ".resp_done"}, 32'(resp_valid), 32'd0);
    chk({tag, ".nreq"}, 32'(mem_log.size()), 32'(exp_nreq));
    if (exp_nreq >= 1 && mem_log.size() >= 1) chk({tag, ".addr0"}, mem_log[0], wa);
    if (exp_nreq >= 2 && mem_log.size() >= 2) chk({tag, ".addr1"}, mem_log[1], wa + 32'd4);
  endtask

  initial begin
    int n;
    int rv0;
    reset_n       = 1'b0;
    sel           = 1'b0;
    req_valid     = 1'b0;
    req_addr      = '0;
    req_op        = '0;
    resp_ready    = 1'b1;
    mem_req_ready = 1'b1;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(req_ready_a), 32'd1);
    chk("rst.mem_req_valid", 32'(mem_req_valid_a), 32'd0);
    chk("rst.mem_addr", mem_addr_a, 32'd0);
    chk("rst.resp_valid", 32'(resp_valid_a), 32'd0);
    chk("rst.resp_data", resp_data_a, 32'd0);
    chk("rst.resp_err_b", 32'(resp_err_b), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_load("lb_100",  1'b0, 32'h100, 3'd3, 32'hFFFFFFF0, 1'b0, 3, 1, 0, 0);
    run_load("lbu_100", 1'b0, 32'h100, 3'd4, 32'h000000F0, 1'b0, 3, 1, 0, 0);
    run_load("lb_101",  1'b0, 32'h101, 3'd3, 32'h00000060, 1'b0, 3, 1, 0, 0);
    run_load("lh_102",  1'b0, 32'h102, 3'd1, 32'hFFFF8070, 1'b0, 3, 1, 0, 0);
    run_load("lhu_102", 1'b0, 32'h102, 3'd2, 32'h00008070, 1'b0, 3, 1, 0, 0);
    run_load("lw_100",  1'b0, 32'h100, 3'd0, 32'h807060F0, 1'b0, 3, 1, 0, 0);
    run_load("op7_100", 1'b0, 32'h100, 3'd7, 32'h807060F0, 1'b0, 3, 1, 0, 0);
    run_load("lw_102",  1'b0, 32'h102, 3'd0, 32'h33448070, 1'b0, 5, 2, 0, 0);
    run_load("lh_103",  1'b0, 32'h103, 3'd1, 32'h00004480, 1'b0, 5, 2, 0, 0);

    run_load("strict_lw_102", 1'b1, 32'h102, 3'd0, 32'h00000000, 1'b1, 1, 0, 0, 0);
    run_load("strict_lh_102", 1'b1, 32'h102, 3'd1, 32'hFFFF8070, 1'b0, 3, 1, 0, 0);

    run_load("mrdy_lo", 1'b0, 32'h100, 3'd0, 32'h807060F0, 1'b0, 6, 1, 3, 0);
    rdelay = 4;
    run_load("rv_delay", 1'b0, 32'h102, 3'd1, 32'hFFFF8070, 1'b0, -1, 1, 0, 0);
    rdelay = 0;
    run_load("resp_lo", 1'b0, 32'h100, 3'd3, 32'hFFFFFFF0, 1'b0, -1, 1, 0, 5);

    // Abort a split LW while it waits for its second word.
    sel    = 1'b0;
    rdelay = 2;
    mem_log.delete();
    rv0       = rv_cnt;
    req_valid = 1'b1;
    req_addr  = 32'h102;
    req_op    = 3'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (mem_log.size() < 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort.second_req", 32'(mem_log.size()), 32'd2);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("abort.req_ready", 32'(req_ready), 32'd1);
    chk("abort.mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("abort.mem_addr", mem_addr, 32'd0);
    chk("abort.resp_valid", 32'(resp_valid), 32'd0);
    chk("abort.resp_data", resp_data, 32'd0);
    chk("abort.resp_err", 32'(resp_err), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort.late_rvalid_ignored", 32'(resp_valid), 32'd0);
    end
    chk("abort.late_rvalid_seen", 32'(rv_cnt - rv0), 32'd2);
    chk("abort.idle", 32'(req_ready), 32'd1);
    rdelay = 0;
    run_load("post_abort_lb_101", 1'b0, 32'h101, 3'd3, 32'h00000060, 1'b0, 3, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
